// File: rtl/udp_tx_sched_if.sv
// Scheduler bus: packet-source channels on one side, the shared UDP TX framer on the other.
// master = scheduler; slave = sources + framer (or a bench standing in for them).
interface udp_tx_sched_if #(
    parameter int NUM_CH = 4
);
    logic                 link_up;
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH*16-1:0] ch_len;
    logic [NUM_CH*32-1:0] ch_data;
    logic [NUM_CH-1:0]    ch_rd;
    logic [NUM_CH-1:0]    ch_grant;
    logic [NUM_CH-1:0]    ch_done;
    logic                 ch_err;
    logic                 tx_start_en;
    logic [15:0]          tx_byte_num;
    logic [31:0]          tx_data;
    logic                 tx_request;
    logic                 tx_done;

    modport master (
        input  link_up, ch_req, ch_len, ch_data, tx_request, tx_done,
        output ch_rd, ch_grant, ch_done, ch_err, tx_start_en, tx_byte_num, tx_data
    );

    modport slave (
        output link_up, ch_req, ch_len, ch_data, tx_request, tx_done,
        input  ch_rd, ch_grant, ch_done, ch_err, tx_start_en, tx_byte_num, tx_data
    );
endinterface

// File: rtl/udp_tx_sched.sv
// Round-robin scheduler sharing one UDP TX framer between NUM_CH packet sources,
// with length screening, inter-frame gap and a hung-framer timeout.
module udp_tx_sched #(
    parameter int NUM_CH      = 4,
    parameter int MAX_LEN     = 1472,
    parameter int IFG_CYC     = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic           clk,
    input  logic           rst_n,
    udp_tx_sched_if.master bus
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int GW = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_REJECT,
        S_START,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     owner;
    logic [CW-1:0]     win_idx;
    logic [CW-1:0]     scan_idx;
    logic [CW-1:0]     rr_nxt;
    logic              found;
    logic [15:0]       win_len;
    logic              len_bad;
    logic [15:0]       len_q;
    logic [15:0]       words_left;
    logic [TW-1:0]     timer;
    logic [GW-1:0]     gap_cnt;
    logic [31:0]       tx_data_q;
    logic              in_wait;
    logic              pop;
    logic              timeout;
    logic [NUM_CH-1:0] owner_oh;

    // First requester at or after rr_ptr, wrapping around the channel list.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = CW'((int'(rr_ptr) + i) % NUM_CH);
            if (!found && bus.ch_req[scan_idx]) begin
                found   = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    assign win_len  = bus.ch_len[16*win_idx +: 16];
    assign len_bad  = (win_len == 16'd0) || (int'(win_len) > MAX_LEN);
    assign rr_nxt   = (win_idx == CW'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;

    assign in_wait  = (state == S_WAIT_DONE);
    assign pop      = in_wait && bus.tx_request && (words_left != 16'd0);
    assign timeout  = in_wait && (timer == TW'(TIMEOUT_CYC - 1));
    assign owner_oh = NUM_CH'(1) << owner;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (bus.link_up && |bus.ch_req) state_nxt = S_ARB;
            S_ARB: begin
                if (!found)       state_nxt = S_IDLE;
                else if (len_bad) state_nxt = S_REJECT;
                else              state_nxt = S_START;
            end
            S_REJECT:    state_nxt = S_IDLE;
            S_START:     state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (bus.tx_done || timeout) state_nxt = S_GAP;
            S_GAP:       if (gap_cnt == GW'(IFG_CYC - 1)) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            len_q      <= '0;
            words_left <= '0;
            timer      <= '0;
            gap_cnt    <= '0;
            tx_data_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_ARB: begin
                    if (found) begin
                        owner  <= win_idx;
                        rr_ptr <= rr_nxt;
                        if (!len_bad) begin
                            len_q      <= win_len;
                            words_left <= 16'((17'(win_len) + 17'd3) >> 2);
                        end
                    end
                end
                S_START: timer <= '0;
                S_WAIT_DONE: begin
                    timer   <= timer + 1'b1;
                    gap_cnt <= '0;
                    // A request with the tail already delivered leaves tx_data untouched.
                    if (pop) begin
                        tx_data_q  <= bus.ch_data[32*owner +: 32];
                        words_left <= words_left - 16'd1;
                    end
                end
                S_GAP: gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.ch_rd       = pop ? owner_oh : '0;
    assign bus.ch_grant    = (state == S_START || in_wait) ? owner_oh : '0;
    assign bus.ch_done     = ((state == S_REJECT) || (in_wait && (bus.tx_done || timeout)))
                             ? owner_oh : '0;
    assign bus.ch_err      = (state == S_REJECT) || (timeout && !bus.tx_done);
    assign bus.tx_start_en = (state == S_START);
    assign bus.tx_byte_num = len_q;
    assign bus.tx_data     = tx_data_q;
endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed bench for udp_tx_sched: the bench plays both the packet sources and the framer.
module tb_udp_tx_sched;
    localparam int NUM_CH = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n_start  = 0;
    int   n_rd     = 0;
    int   n_err    = 0;
    int   done_cyc = 0;
    int   start_cyc;
    int   s_start;
    int   s_rd;
    int   s_err;
    bit   seen;
    logic [31:0] words [4];

    udp_tx_sched_if #(.NUM_CH(NUM_CH)) bus ();

    udp_tx_sched #(.NUM_CH(NUM_CH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        n_start <= n_start + int'(bus.tx_start_en);
        n_rd    <= n_rd + $countones(bus.ch_rd);
        n_err   <= n_err + int'(bus.ch_err);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d required=<50000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            #1;
            if (bus.tx_start_en) found = 1'b1;
        end
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            #1;
            if (|bus.ch_done) found = 1'b1;
        end
    endtask

    task automatic set_ch(input int ch, input int len);
        bus.ch_len[16*ch +: 16]  = 16'(len);
        bus.ch_data[32*ch +: 32] = words[0];
        bus.ch_req[ch]           = 1'b1;
    endtask

    // Called right after tx_start_en was seen; plays the framer for one frame.
    task automatic frame(input int ch, input int len, input int nreq);
        int nw;
        logic [NUM_CH-1:0] oh;
        nw = (len + 3) / 4;
        oh = NUM_CH'(1) << ch;
        for (int k = 0; k < nreq; k++) begin
            @(negedge clk);
            if (k < nw) bus.ch_data[32*ch +: 32] = words[k];
            bus.tx_request = 1'b1;
            #1;
            check("ch_rd", 64'(bus.ch_rd), (k < nw) ? 64'(oh) : 64'd0);
            @(negedge clk);
            bus.tx_request = 1'b0;
            #1;
            check("tx_data", 64'(bus.tx_data), 64'(words[(k < nw) ? k : nw - 1]));
        end
        @(negedge clk);
        bus.tx_done = 1'b1;
        done_cyc    = cyc;
        #1;
        check("ch_done", 64'(bus.ch_done), 64'(oh));
        check("ch_err_clean", 64'(bus.ch_err), 64'd0);
        @(negedge clk);
        bus.tx_done    = 1'b0;
        bus.ch_req[ch] = 1'b0;
        #1;
        check("grant_drop", 64'(bus.ch_grant), 64'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.link_up    = 1'b0;
        bus.ch_req     = '0;
        bus.ch_len     = '0;
        bus.ch_data    = '0;
        bus.tx_request = 1'b0;
        bus.tx_done    = 1'b0;
        words          = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_outs", {bus.ch_rd, bus.ch_grant, bus.ch_done, bus.ch_err,
                           bus.tx_start_en, bus.tx_byte_num, bus.tx_data}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_start", 64'(bus.tx_start_en), 64'd0);

        // Single channel, len 8: one start, two pops
        bus.link_up = 1'b1;
        s_start = n_start;
        s_rd    = n_rd;
        set_ch(1, 8);
        wait_start(5, seen);
        check("t1_start_seen", 64'(seen), 64'd1);
        check("t1_grant", 64'(bus.ch_grant), 64'h2);
        check("t1_byte_num", 64'(bus.tx_byte_num), 64'd8);
        frame(1, 8, 2);
        check("t1_n_start", 64'(n_start - s_start), 64'd1);
        check("t1_n_rd", 64'(n_rd - s_rd), 64'd2);

        // Fresh reset so rr_ptr is 0, then three simultaneous requesters
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_ch(0, 4);
        set_ch(2, 4);
        set_ch(3, 4);
        wait_start(5, seen);
        check("t2_start0", 64'(seen), 64'd1);
        check("t2_grant0", 64'(bus.ch_grant), 64'h1);
        frame(0, 4, 1);
        wait_start(40, seen);
        check("t2_start2", 64'(seen), 64'd1);
        check("t2_grant2", 64'(bus.ch_grant), 64'h4);
        check("t2_gap02", 64'((start_cyc - done_cyc) >= 17 && (start_cyc - done_cyc) <= 20), 64'd1);
        frame(2, 4, 1);
        wait_start(40, seen);
        check("t2_start3", 64'(seen), 64'd1);
        check("t2_grant3", 64'(bus.ch_grant), 64'h8);
        check("t2_gap23", 64'((start_cyc - done_cyc) >= 17 && (start_cyc - done_cyc) <= 20), 64'd1);
        frame(3, 4, 1);

        // Bad lengths: ch0 len 0, ch1 len 1500
        s_start = n_start;
        s_rd    = n_rd;
        s_err   = n_err;
        set_ch(0, 0);
        set_ch(1, 1500);
        wait_done(40, seen);
        check("t3_rej0_seen", 64'(seen), 64'd1);
        check("t3_rej0_done", 64'(bus.ch_done), 64'h1);
        check("t3_rej0_err", 64'(bus.ch_err), 64'd1);
        bus.ch_req[0] = 1'b0;
        wait_done(10, seen);
        check("t3_rej1_seen", 64'(seen), 64'd1);
        check("t3_rej1_done", 64'(bus.ch_done), 64'h2);
        check("t3_rej1_err", 64'(bus.ch_err), 64'd1);
        bus.ch_req[1] = 1'b0;
        @(negedge clk);
        check("t3_no_start", 64'(n_start - s_start), 64'd0);
        check("t3_no_rd", 64'(n_rd - s_rd), 64'd0);
        check("t3_n_err", 64'(n_err - s_err), 64'd2);

        // len 5: three framer requests, only two pops
        s_rd = n_rd;
        set_ch(2, 5);
        wait_start(10, seen);
        check("t4_start", 64'(seen), 64'd1);
        check("t4_byte_num", 64'(bus.tx_byte_num), 64'd5);
        frame(2, 5, 3);
        check("t4_n_rd", 64'(n_rd - s_rd), 64'd2);

        // Hung framer on ch3, then ch0 still gets served
        set_ch(3, 8);
        set_ch(0, 4);
        wait_start(40, seen);
        check("t5_start", 64'(seen), 64'd1);
        check("t5_grant", 64'(bus.ch_grant), 64'h8);
        s_start = start_cyc;
        wait_done(5000, seen);
        check("t5_to_seen", 64'(seen), 64'd1);
        check("t5_to_done", 64'(bus.ch_done), 64'h8);
        check("t5_to_err", 64'(bus.ch_err), 64'd1);
        check("t5_to_cycles", 64'(cyc - s_start), 64'd4096);
        bus.ch_req[3] = 1'b0;
        wait_start(40, seen);
        check("t5_next_start", 64'(seen), 64'd1);
        check("t5_next_grant", 64'(bus.ch_grant), 64'h1);
        check("t5_next_len", 64'(bus.tx_byte_num), 64'd4);
        frame(0, 4, 1);

        // link_up low holds off grants; raising it starts within 2 cycles
        bus.link_up = 1'b0;
        set_ch(1, 4);
        wait_start(20, seen);
        check("t6_link_down", 64'(seen), 64'd0);
        bus.link_up = 1'b1;
        wait_start(2, seen);
        check("t6_link_up", 64'(seen), 64'd1);
        check("t6_grant", 64'(bus.ch_grant), 64'h2);
        frame(1, 4, 1);

        // Reset in the middle of a frame clears outputs immediately
        set_ch(2, 8);
        wait_start(40, seen);
        check("t7_start", 64'(seen), 64'd1);
        @(negedge clk);
        bus.tx_request = 1'b1;
        @(negedge clk);
        bus.tx_request = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_outs", {bus.ch_rd, bus.ch_grant, bus.ch_done, bus.ch_err,
                              bus.tx_start_en, bus.tx_byte_num, bus.tx_data}, 64'd0);
        bus.ch_req = '0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
